// File: rtl/mem_bus_ctrl_pkg.sv
// mem_bus_ctrl_pkg: shared sequencer state type and default SRAM timing/width constants
package mem_bus_ctrl_pkg;
  typedef enum logic [2:0] {IDLE, RD, WR_SETUP, WR_PULSE, WR_HOLD} mem_state_t;
  localparam int MEM_RD_WAIT_DEF = 2;
  localparam int MEM_WR_WAIT_DEF = 2;
  localparam int SRAM_AW_DEF = 20;
endpackage

// File: rtl/mem_wait_counter.sv
// mem_wait_counter: 4-bit loadable down-counter; done marks the last cycle of a timed phase
//   clk, rst_n (sync, active-low), load/load_val (reload), done (count == 1)
module mem_wait_counter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [3:0] load_val,
  output logic       done
);
  logic [3:0] cnt_q, cnt_d;
  always_comb cnt_d = load ? load_val : (cnt_q != 4'd0 ? cnt_q - 4'd1 : cnt_q);
  always_ff @(posedge clk) cnt_q <= rst_n ? cnt_d : 4'd0;
  assign done = cnt_q == 4'd1;
endmodule

// File: rtl/mem_bus_ctrl.sv
// mem_bus_ctrl: valid/ready request sequencer driving active-low async SRAM strobes with wait states
//   Clk, Reset (sync, active-low)
//   req_valid/req_we/req_addr/req_wdata/req_ready: request handshake from the control unit
//   rsp_valid/rsp_we/rsp_rdata: one-cycle completion pulse and read data
//   sram_addr/sram_wdata/sram_data_oe/sram_rdata, Mem_CE/UB/LB/OE/WE: SRAM side
//   MEM_BUS_CTRL_STATS_EN adds saturating rd_count/wr_count outputs
module mem_bus_ctrl
  import mem_bus_ctrl_pkg::*;
#(
  parameter int RD_WAIT = MEM_RD_WAIT_DEF,
  parameter int WR_WAIT = MEM_WR_WAIT_DEF,
  parameter int SRAM_AW = SRAM_AW_DEF
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               req_valid,
  input  logic               req_we,
  input  logic [15:0]        req_addr,
  input  logic [15:0]        req_wdata,
  output logic               req_ready,
  output logic               rsp_valid,
  output logic               rsp_we,
  output logic [15:0]        rsp_rdata,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [15:0]        sram_wdata,
  output logic               sram_data_oe,
  input  logic [15:0]        sram_rdata,
`ifdef MEM_BUS_CTRL_STATS_EN
  output logic [15:0]        rd_count,
  output logic [15:0]        wr_count,
`endif
  output logic               Mem_CE,
  output logic               Mem_UB,
  output logic               Mem_LB,
  output logic               Mem_OE,
  output logic               Mem_WE
);
  if (RD_WAIT < 1 || RD_WAIT > 15 || WR_WAIT < 1 || WR_WAIT > 15) begin : g_bad_wait
    $error("mem_bus_ctrl: RD_WAIT and WR_WAIT must be in 1..15");
  end
  mem_state_t  state_q, state_d;
  logic        rsp_valid_q, rsp_valid_d, rsp_we_q, rsp_we_d;
  logic [15:0] rsp_rdata_q, rsp_rdata_d, addr_q, addr_d, wdata_q, wdata_d;
  logic        accept, cnt_load, cnt_done;
  logic [3:0]  cnt_val;
  // The write pulse length is reloaded on leaving WR_SETUP so WR_WAIT=15 never needs a 5th bit.
  always_comb begin
    accept = state_q == IDLE && req_valid;
    cnt_load = accept || state_q == WR_SETUP;
    cnt_val = accept && !req_we ? 4'(RD_WAIT) : 4'(WR_WAIT);
    state_d = state_q;
    rsp_valid_d = 1'b0;
    rsp_we_d = rsp_we_q;
    rsp_rdata_d = rsp_rdata_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    case (state_q)
      IDLE: if (req_valid) begin
        state_d = req_we ? WR_SETUP : RD;
        addr_d = req_addr;
        wdata_d = req_wdata;
      end
      RD: if (cnt_done) begin
        state_d = IDLE;
        rsp_valid_d = 1'b1;
        rsp_we_d = 1'b0;
        rsp_rdata_d = sram_rdata;
      end
      WR_SETUP: state_d = WR_PULSE;
      WR_PULSE: state_d = cnt_done ? WR_HOLD : WR_PULSE;
      WR_HOLD: begin
        state_d = IDLE;
        rsp_valid_d = 1'b1;
        rsp_we_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge Clk) begin
    state_q <= Reset ? state_d : IDLE;
    rsp_valid_q <= Reset ? rsp_valid_d : 1'b0;
    rsp_we_q <= Reset ? rsp_we_d : 1'b0;
    rsp_rdata_q <= Reset ? rsp_rdata_d : 16'h0;
    addr_q <= Reset ? addr_d : 16'h0;
    wdata_q <= Reset ? wdata_d : 16'h0;
  end
  mem_wait_counter u_cnt (
    .clk(Clk),
    .rst_n(Reset),
    .load(cnt_load),
    .load_val(cnt_val),
    .done(cnt_done)
  );
  assign req_ready = Reset && state_q == IDLE;
  assign rsp_valid = rsp_valid_q;
  assign rsp_we = rsp_we_q;
  assign rsp_rdata = rsp_rdata_q;
  assign sram_addr = SRAM_AW'(addr_q);
  assign sram_wdata = wdata_q;
  assign sram_data_oe = state_q == WR_PULSE || state_q == WR_HOLD;
  assign Mem_CE = state_q == IDLE;
  assign Mem_UB = Mem_CE;
  assign Mem_LB = Mem_CE;
  assign Mem_OE = state_q != RD;
  assign Mem_WE = state_q != WR_PULSE;
`ifdef MEM_BUS_CTRL_STATS_EN
  logic [15:0] rd_count_q, rd_count_d, wr_count_q, wr_count_d;
  always_comb begin
    rd_count_d = rd_count_q + 16'(rsp_valid_q && !rsp_we_q && rd_count_q != 16'hFFFF);
    wr_count_d = wr_count_q + 16'(rsp_valid_q && rsp_we_q && wr_count_q != 16'hFFFF);
  end
  always_ff @(posedge Clk) begin
    rd_count_q <= Reset ? rd_count_d : 16'h0;
    wr_count_q <= Reset ? wr_count_d : 16'h0;
  end
  assign rd_count = rd_count_q;
  assign wr_count = wr_count_q;
`endif
endmodule

// File: doc/mem_bus_ctrl.md
Name: mem_bus_ctrl

Overview:
- Memory access sequencer between the control unit/datapath (MAR/MDR) and the async SRAM.
- Replaces fixed multi-state memory reads and writes with a valid/ready request and a response pulse.
- Produces the active-low SRAM strobes with parameterised wait states.
- The control unit issues one request per memory state and waits for rsp_valid.

Parameters:
- RD_WAIT, 2, number of cycles Mem_OE is held low per read (1..15).
- WR_WAIT, 2, number of cycles Mem_WE is held low per write (1..15).
- SRAM_AW, 20, SRAM address width; CPU address is zero-extended.

Ports:
- Clk  in  1  system clock, rising edge.
- Reset  in  1  synchronous, active-low reset.
- req_valid  in  1  request present.
- req_we  in  1  1=write, 0=read.
- req_addr  in  16  word address (from MAR).
- req_wdata  in  16  write data (from MDR).
- req_ready  out  1  controller can accept a request.
- rsp_valid  out  1  one-cycle pulse: access complete.
- rsp_we  out  1  type of the completed access.
- rsp_rdata  out  16  read data, valid with rsp_valid when rsp_we=0.
- sram_addr  out  SRAM_AW  SRAM address.
- sram_wdata  out  16  data to drive onto the SRAM bus.
- sram_data_oe  out  1  tri-state enable for sram_wdata (top-level wrapper owns the pad).
- sram_rdata  in  16  data sampled from the SRAM bus.
- Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE  out  1 each  active-low SRAM controls.

Behaviour:
- Reset (Reset=0 at a rising edge) leaves the block in this state on the next cycle:
  - state=IDLE; counter=0.
  - rsp_valid=0, rsp_we=0, rsp_rdata=0, sram_addr=0, sram_wdata=0, sram_data_oe=0.
  - Mem_CE/OE/WE/UB/LB=1.
  - req_ready=0 while Reset=0.
- All outputs are registered or decoded from the state register; there is no combinational path from req_* to SRAM pins.
- States: IDLE, RD, WR_SETUP, WR_PULSE, WR_HOLD.
- IDLE:
  - req_ready=1; a request is accepted on an edge where req_valid=1.
  - On accept, latch addr and wdata, load counter, and go to RD (req_we=0) or WR_SETUP (req_we=1).
  - With req_valid=0, stay in IDLE.
- RD: Mem_CE=0, Mem_OE=0, sram_data_oe=0.
  - Lasts exactly RD_WAIT cycles.
  - On the edge ending the last RD cycle, capture sram_rdata into rsp_rdata and return to IDLE.
  - rsp_valid=1, rsp_we=0 in the following cycle.
- WR_SETUP (1 cycle): Mem_CE=0, Mem_WE=1, sram_data_oe=0. This cycle gives the bus turnaround after a preceding read.
- WR_PULSE (WR_WAIT cycles): Mem_CE=0, Mem_WE=0, sram_data_oe=1.
- WR_HOLD (1 cycle): Mem_CE=0, Mem_WE=1, sram_data_oe=1. Then go to IDLE with rsp_valid=1, rsp_we=1.
- Mem_UB=Mem_LB=0 whenever Mem_CE=0; otherwise 1.
- sram_addr={zeros, latched addr}; it holds its value between accesses.
- Latency (accept edge = edge 0):
  - Read: rsp_valid is high in cycle RD_WAIT+1.
  - Write: rsp_valid is high in cycle WR_WAIT+3.
- rsp_valid and req_ready may be high in the same cycle, so back-to-back accepts are allowed with zero idle cycles.
- rsp_rdata holds its value until the next read completes.
- Counter is 4 bits and counts down. The state exits when counter==1, so it never wraps.
- Requests are ignored outside IDLE: there is no queue and no error flag. The requester must hold req_valid until accepted.
- Reset mid-access: the access is abandoned at the next edge, strobes deassert, and no rsp_valid is issued.
- Out-of-range RD_WAIT/WR_WAIT is a static assertion failure at elaboration.

Optional Feature:
- Macro: MEM_BUS_CTRL_STATS_EN.
- Defined:
  - Adds outputs rd_count[15:0] and wr_count[15:0].
  - Each increments on its rsp_valid pulse and saturates at 16'hFFFF.
  - Both clear on reset.
- Undefined: these ports and registers do not exist. All other behaviour is identical.

Decomposition:
- The shared types package (alongside the opcode/ALU enums) gets:
  - typedef mem_state_t.
  - constants MEM_RD_WAIT_DEF=2, MEM_WR_WAIT_DEF=2, SRAM_AW_DEF=20.
- One natural sub-module: mem_wait_counter (load, count-down, done flag), instantiated once.

Test Plan:
- Reset held low 3 cycles during RD → outputs at the reset values above, no rsp_valid; after release, req_ready=1 within 1 cycle.
- Read addr 16'h0012 with sram_rdata=16'hBEEF, RD_WAIT=2 → Mem_OE low exactly cycles 1-2; rsp_valid in cycle 3; rsp_rdata=16'hBEEF; sram_addr=20'h00012.
- Write 16'h1234 to 16'h0030, WR_WAIT=2 → WE low cycles 2-3; sram_data_oe high cycles 2-4; rsp_valid cycle 5, rsp_we=1.
- Read then write back-to-back (req_valid held) → write accepted in the read's rsp_valid cycle; sram_data_oe stays 0 in WR_SETUP.
- req_valid toggled while in WR_PULSE → no second accept; exactly one rsp_valid.
- With MEM_BUS_CTRL_STATS_EN: 3 reads + 2 writes → rd_count=3, wr_count=2. Force rd_count=16'hFFFF, one more read → stays 16'hFFFF.
